// File: rtl/spi_slave_rx_dual.sv
// Dual-lane SPI mode-0 receive slave: lane 2 carries the upper byte, lane 1 the lower byte.
// Completed words are handed off through a valid/ready register with sticky overrun.
module spi_slave_rx_dual #(
  parameter bit SYNC_EN = 1'b0
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        i_sck,
  input  logic        i_cs,
  input  logic        i_rx_ch1,
  input  logic        i_rx_ch2,
  output logic [15:0] o_rx_data,
  output logic        o_rx_valid,
  input  logic        i_rx_ready,
  output logic        o_frame_err,
  output logic        o_overrun,
  input  logic        i_clr_overrun
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    WAIT_CS
  } state_e;

  logic sckS, csS, d1S, d2S;

  // cs synchronizer resets high so a reset never manufactures a cs-fall
  if (SYNC_EN) begin : gSync
    logic [1:0] sckSync_q, csSync_q, d1Sync_q, d2Sync_q;

    always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
        sckSync_q <= 2'b00;
        csSync_q  <= 2'b11;
        d1Sync_q  <= 2'b00;
        d2Sync_q  <= 2'b00;
      end else begin
        sckSync_q <= {sckSync_q[0], i_sck};
        csSync_q  <= {csSync_q[0], i_cs};
        d1Sync_q  <= {d1Sync_q[0], i_rx_ch1};
        d2Sync_q  <= {d2Sync_q[0], i_rx_ch2};
      end
    end

    assign sckS = sckSync_q[1];
    assign csS  = csSync_q[1];
    assign d1S  = d1Sync_q[1];
    assign d2S  = d2Sync_q[1];
  end else begin : gDirect
    assign sckS = i_sck;
    assign csS  = i_cs;
    assign d1S  = i_rx_ch1;
    assign d2S  = i_rx_ch2;
  end

  state_e      state_q, state_d;
  logic        sckD_q, csD_q;
  logic [2:0]  cnt_q, cnt_d;
  logic [7:0]  sh1_q, sh1_d, sh2_q, sh2_d;
  logic [15:0] data_q, data_d;
  logic        valid_q, valid_d;
  logic        frameErr_q, frameErr_d;
  logic        overrun_q, overrun_d;

  logic        sckRise, csFall, csRise, wordDone;
  logic [15:0] word;

  assign sckRise = sckS & ~sckD_q;
  assign csFall  = csD_q & ~csS;
  assign csRise  = ~csD_q & csS;
  assign word    = {sh2_q[6:0], d2S, sh1_q[6:0], d1S};

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q    <= IDLE;
      sckD_q     <= 1'b0;
      csD_q      <= 1'b1;
      cnt_q      <= 3'd0;
      sh1_q      <= 8'h00;
      sh2_q      <= 8'h00;
      data_q     <= 16'h0000;
      valid_q    <= 1'b0;
      frameErr_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      sckD_q     <= sckS;
      csD_q      <= csS;
      cnt_q      <= cnt_d;
      sh1_q      <= sh1_d;
      sh2_q      <= sh2_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      frameErr_q <= frameErr_d;
      overrun_q  <= overrun_d;
    end
  end

  // The 8th rise finishes a word; counter never needs a value beyond 7
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sh1_d      = sh1_q;
    sh2_d      = sh2_q;
    data_d     = data_q;
    valid_d    = valid_q;
    frameErr_d = 1'b0;
    overrun_d  = overrun_q;
    wordDone   = 1'b0;

    if (valid_q && i_rx_ready) valid_d = 1'b0;
    if (i_clr_overrun) overrun_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (csFall) begin
          state_d = SHIFT;
          cnt_d   = 3'd0;
          sh1_d   = 8'h00;
          sh2_d   = 8'h00;
        end
      end
      SHIFT: begin
        if (csRise) begin
          state_d    = IDLE;
          cnt_d      = 3'd0;
          frameErr_d = (cnt_q != 3'd0);
        end else if (sckRise && !csS) begin
          sh1_d = {sh1_q[6:0], d1S};
          sh2_d = {sh2_q[6:0], d2S};
          if (cnt_q == 3'd7) begin
            wordDone = 1'b1;
            state_d  = WAIT_CS;
            cnt_d    = 3'd0;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end
      WAIT_CS: begin
        if (csRise) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A new overrun takes priority over a same-cycle clear
    if (wordDone) begin
      if (!valid_q || i_rx_ready) begin
        data_d  = word;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  assign o_rx_data   = data_q;
  assign o_rx_valid  = valid_q;
  assign o_frame_err = frameErr_q;
  assign o_overrun   = overrun_q;

endmodule
